// File: rtl/xor_checksum_unit_pkg.sv
// Shared constants for the streaming XOR checksum unit: FSM state
// encodings and parameter defaults.
package xor_checksum_unit_pkg;

  // FSM state width and encodings (kept as plain constants so they match
  // the encodings used elsewhere in the data path).
  localparam int         STATE_W  = 2;
  localparam logic [1:0] ST_IDLE  = 2'd0;  // no word of the frame yet
  localparam logic [1:0] ST_ACCUM = 2'd1;  // at least one word accepted
  localparam logic [1:0] ST_HOLD  = 2'd2;  // result presented, waiting for consumer

  // Parameter defaults.
  localparam int   DEF_WIDTH = 8;
  localparam int   DEF_CNT_W = 8;
  localparam logic DEF_ODD   = 1'b0;  // 0 = even parity, 1 = odd parity

endpackage

// File: rtl/xor_checksum_unit_xor_word_n.sv
// WIDTH-bit bitwise XOR assembled from one 2-input XOR cell per bit.
// Used by the checksum unit to fold an incoming word into the accumulator.
module xor_word_n
  import xor_checksum_unit_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y
);

  // One 2-input XOR cell per bit column.
  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    assign y[i] = a[i] ^ b[i];
  end

endmodule

// File: rtl/xor_checksum_unit.sv
// Streaming longitudinal XOR checksum. Words arrive over a valid/ready
// handshake and are folded column-wise into an accumulator. After the last
// word of a frame the checksum, a parity bit and a saturating word count are
// held until the consumer takes them.
module xor_checksum_unit
  import xor_checksum_unit_pkg::*;
#(
  parameter int               WIDTH = DEF_WIDTH,
  parameter int               CNT_W = DEF_CNT_W,
  parameter logic [WIDTH-1:0] SEED  = '0,
  parameter logic             ODD   = DEF_ODD
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_checksum,
  output logic             out_parity,
  output logic [CNT_W-1:0] out_count,
  output logic             out_sat,
  input  logic             out_ready
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [STATE_W-1:0] state;
  logic [WIDTH-1:0]   acc;
  logic [WIDTH-1:0]   acc_nxt;
  logic [CNT_W-1:0]   count;
  logic               sat;
  logic               accept;

  // Handshake flags decode the registered state only, so there is no
  // combinational path from in_valid or out_ready to any output.
  assign in_ready  = (state != ST_HOLD);
  assign out_valid = (state == ST_HOLD);
  assign accept    = in_valid & in_ready;

  xor_word_n #(
    .WIDTH (WIDTH)
  ) u_fold (
    .a (acc),
    .b (in_data),
    .y (acc_nxt)
  );

  // Frame FSM plus accumulator, counter and saturation flag.
  // NOTE: all state here uses non-blocking assignments so every register
  // samples the pre-edge value of every other register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
      acc   <= SEED;
      count <= '0;
      sat   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_ACCUM: begin
          if (accept) begin
            acc <= acc_nxt;
            // Count stops at its maximum; one more word marks saturation
            // while the checksum keeps folding.
            if (count == CNT_MAX) begin
              sat <= 1'b1;
            end else begin
              count <= count + 1'b1;
            end
            state <= in_last ? ST_HOLD : ST_ACCUM;
          end
        end
        ST_HOLD: begin
          // in_valid is ignored here; the result stays frozen until taken.
          if (out_ready) begin
            state <= ST_IDLE;
            acc   <= SEED;
            count <= '0;
            sat   <= 1'b0;
          end
        end
        default: begin
          state <= ST_IDLE;
          acc   <= SEED;
          count <= '0;
          sat   <= 1'b0;
        end
      endcase
    end
  end

  assign out_checksum = acc;
  assign out_count    = count;
  assign out_sat      = sat;
  assign out_parity   = (^acc) ^ ODD;

endmodule

// File: tb/tb_xor_checksum_unit.sv
// Self-checking bench for xor_checksum_unit. A queue-based model of each
// frame predicts the outputs of the default-configured instance every cycle;
// two extra instances (odd parity, 2-bit counter) cover parameter corners.
module tb_xor_checksum_unit;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  // Main instance: WIDTH=8, CNT_W=8, SEED=0, ODD=0
  logic       in_valid, in_last, out_ready;
  logic [7:0] in_data;
  logic       in_ready, out_valid, out_parity, out_sat;
  logic [7:0] out_checksum, out_count;

  // Auxiliary instances share one stimulus set.
  logic       a_valid, a_last, a_out_ready;
  logic [7:0] a_data;
  logic       o_ready, o_valid, o_parity, o_sat;
  logic [7:0] o_checksum, o_count;
  logic       s_ready, s_valid, s_parity, s_sat;
  logic [7:0] s_checksum;
  logic [1:0] s_count;

  xor_checksum_unit #(.WIDTH(8), .CNT_W(8), .SEED(8'h00), .ODD(1'b0)) dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_data(in_data), .in_last(in_last), .in_ready(in_ready),
    .out_valid(out_valid), .out_checksum(out_checksum), .out_parity(out_parity),
    .out_count(out_count), .out_sat(out_sat), .out_ready(out_ready)
  );

  xor_checksum_unit #(.WIDTH(8), .CNT_W(8), .SEED(8'h00), .ODD(1'b1)) dut_odd (
    .clock(clock), .reset(reset),
    .in_valid(a_valid), .in_data(a_data), .in_last(a_last), .in_ready(o_ready),
    .out_valid(o_valid), .out_checksum(o_checksum), .out_parity(o_parity),
    .out_count(o_count), .out_sat(o_sat), .out_ready(a_out_ready)
  );

  xor_checksum_unit #(.WIDTH(8), .CNT_W(2), .SEED(8'h00), .ODD(1'b0)) dut_sat (
    .clock(clock), .reset(reset),
    .in_valid(a_valid), .in_data(a_data), .in_last(a_last), .in_ready(s_ready),
    .out_valid(s_valid), .out_checksum(s_checksum), .out_parity(s_parity),
    .out_count(s_count), .out_sat(s_sat), .out_ready(a_out_ready)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model of the main instance ----------------
  // The frame is kept as the list of words accepted so far; outputs are
  // derived from that list directly.
  logic [7:0] frame_q[$];
  bit         m_hold = 1'b0;

  function automatic logic [7:0] model_xor();
    logic [7:0] r = 8'h00;  // SEED
    foreach (frame_q[i]) r = r ^ frame_q[i];
    return r;
  endfunction

  always @(posedge clock) begin
    if (reset) begin
      frame_q.delete();
      m_hold = 1'b0;
    end else if (m_hold) begin
      if (out_ready) begin
        frame_q.delete();
        m_hold = 1'b0;
      end
    end else if (in_valid) begin
      frame_q.push_back(in_data);
      if (in_last) m_hold = 1'b1;
    end
  end

  // Compare every cycle, away from the active edge.
  always @(negedge clock) begin
    if (!reset) begin
      logic [7:0] exp_sum;
      int         n;
      exp_sum = model_xor();
      n = frame_q.size();
      check("in_ready",  32'(in_ready),     32'(!m_hold));
      check("out_valid", 32'(out_valid),    32'(m_hold));
      check("checksum",  32'(out_checksum), 32'(exp_sum));
      check("parity",    32'(out_parity),   32'(^exp_sum));
      check("count",     32'(out_count),    32'((n > 255) ? 255 : n));
      check("sat",       32'(out_sat),      32'(n > 255));
    end
  end

  // ---------------- stimulus helpers ----------------
  // Offer one word and wait (bounded) until it is accepted.
  task automatic send_word(input logic [7:0] d, input logic last);
    int n = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    while (!in_ready && n < 100) begin
      @(posedge clock); #1;
      n++;
    end
    if (n == 100) check("accept_timeout", 32'(n), 32'(0));
    @(posedge clock); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(posedge clock); #1;
    out_ready = 1'b0;
  endtask

  task automatic send_aux(input logic [7:0] d, input logic last);
    a_valid = 1'b1;
    a_data  = d;
    a_last  = last;
    @(posedge clock); #1;
    a_valid = 1'b0;
    a_last  = 1'b0;
  endtask

  logic [7:0] sat_words [5];

  initial begin
    reset = 1'b1;
    in_valid = 1'b0; in_last = 1'b0; in_data = 8'h00; out_ready = 1'b0;
    a_valid = 1'b0; a_last = 1'b0; a_data = 8'h00; a_out_ready = 1'b0;
    sat_words[0] = 8'h01; sat_words[1] = 8'h02; sat_words[2] = 8'h04;
    sat_words[3] = 8'h08; sat_words[4] = 8'h10;

    // Reset state, visible immediately because reset is asynchronous.
    #1;
    check("rst_in_ready",  32'(in_ready),     32'(1));
    check("rst_out_valid", 32'(out_valid),    32'(0));
    check("rst_checksum",  32'(out_checksum), 32'h00);
    check("rst_count",     32'(out_count),    32'(0));
    check("rst_parity",    32'(out_parity),   32'(0));
    check("rst_sat",       32'(out_sat),      32'(0));
    check("rst_odd_parity", 32'(o_parity),    32'(1));
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;

    // Frame 3C A5 0F back-to-back, consumer stalled for 5 cycles.
    send_word(8'h3C, 1'b0);
    send_word(8'hA5, 1'b0);
    send_word(8'h0F, 1'b1);
    check("f1_valid",    32'(out_valid),    32'(1));
    check("f1_checksum", 32'(out_checksum), 32'h96);
    check("f1_parity",   32'(out_parity),   32'(0));
    check("f1_count",    32'(out_count),    32'(3));
    check("f1_in_ready", 32'(in_ready),     32'(0));
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_data = 8'hFF; in_last = i[0];
      @(posedge clock); #1;
      check("hold_checksum", 32'(out_checksum), 32'h96);
      check("hold_count",    32'(out_count),    32'(3));
      check("hold_valid",    32'(out_valid),    32'(1));
    end
    in_valid = 1'b0; in_last = 1'b0;
    consume();
    check("taken_in_ready",  32'(in_ready),     32'(1));
    check("taken_valid",     32'(out_valid),    32'(0));
    check("taken_checksum",  32'(out_checksum), 32'h00);

    // Reset after two words discards the partial frame.
    send_word(8'h11, 1'b0);
    send_word(8'h22, 1'b0);
    reset = 1'b1;
    #1;
    check("midrst_count",    32'(out_count),    32'(0));
    check("midrst_checksum", 32'(out_checksum), 32'h00);
    @(posedge clock); #1;
    reset = 1'b0;
    send_word(8'hFF, 1'b1);
    check("postrst_checksum", 32'(out_checksum), 32'hFF);
    check("postrst_count",    32'(out_count),    32'(1));
    consume();

    // 300-word frame saturates the 8-bit counter.
    for (int i = 0; i < 300; i++) send_word(8'($urandom), (i == 299));
    check("long_count", 32'(out_count), 32'(255));
    check("long_sat",   32'(out_sat),   32'(1));
    consume();
    check("long_sat_clr", 32'(out_sat), 32'(0));

    // Randomised frames, gaps, junk during hold and stalled consumers.
    for (int f = 0; f < 200; f++) begin
      int len;
      len = int'($urandom_range(1, 8));
      for (int w = 0; w < len; w++) begin
        int gap;
        gap = int'($urandom_range(0, 2));
        out_ready = 1'($urandom);
        repeat (gap) begin
          in_valid = 1'b0; in_data = 8'($urandom);
          @(posedge clock); #1;
        end
        send_word(8'($urandom), (w == len - 1));
      end
      repeat ($urandom_range(0, 3)) begin
        out_ready = 1'b0;
        in_valid = 1'($urandom); in_data = 8'($urandom); in_last = 1'($urandom);
        @(posedge clock); #1;
      end
      in_valid = 1'b0; in_last = 1'b0;
      consume();
    end

    // Odd parity single-word frame and 2-bit counter saturation.
    check("aux_ready", 32'({o_ready, s_ready}), 32'(3));
    send_aux(8'h01, 1'b1);
    check("odd_valid",    32'(o_valid),    32'(1));
    check("odd_checksum", 32'(o_checksum), 32'h01);
    check("odd_parity",   32'(o_parity),   32'(0));
    check("odd_count",    32'(o_count),    32'(1));
    check("sat1_sat",     32'(s_sat),      32'(0));
    a_out_ready = 1'b1; @(posedge clock); #1; a_out_ready = 1'b0;
    for (int i = 0; i < 5; i++) send_aux(sat_words[i], (i == 4));
    check("sat_valid",    32'(s_valid),    32'(1));
    check("sat_count",    32'(s_count),    32'(3));
    check("sat_flag",     32'(s_sat),      32'(1));
    check("sat_checksum", 32'(s_checksum), 32'h1F);
    check("odd5_count",   32'(o_count),    32'(5));
    check("odd5_parity",  32'(o_parity),   32'(0));

    @(negedge clock);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, checks %0d errors %0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule
